sram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the external 16-bit asynchronous SRAM in the veriRISCV SoC. It accepts 32-bit word requests from an instruction port (port 0) and a data port (port 1), and grants them round-robin. Each granted request is split into low and high 16-bit SRAM phases, and completion is returned with a one-cycle ready pulse. It sits between the core bus ports and the `sram_*` pins.

---
 rtl/sram_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-port arbiter and sequencer for the external 16-bit asynchronous SRAM.
// Port 0 (instruction) and port 1 (data) issue 32-bit word requests. Requests
// are granted round-robin. Each granted access is split into a low and a
// high 16-bit SRAM phase, and completion is signalled with a one-cycle ready
// pulse on the granted port.
//
// Parameters:
//   SRAM_AW  halfword address width of the SRAM
//   SRAM_DW  SRAM data width (only 16 is supported)
//   ACC_CYC  cycles per SRAM phase (minimum 2)
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   pN_req_i                 request, held stable until pN_ready_o
//   pN_we_i                  1 = write, 0 = read
//   pN_addr_i                byte address, bits [SRAM_AW:2] select the word
//   pN_wdata_i, pN_be_i      write data and byte enables
//   pN_ready_o               one-cycle completion pulse
//   pN_rdata_o               read data, held until the port's next read
//   sram_ce_n_o/oe_n_o/we_n_o  SRAM controls, active-low
//   sram_be_n_o              SRAM byte lane enables, active-low
//   sram_addr_o              SRAM halfword address
//   sram_dq_io               SRAM data bus, driven only during write phases
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int SRAM_AW = 19,
  parameter int SRAM_DW = 16,
  parameter int ACC_CYC = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   p0_req_i,
  input  logic                   p0_we_i,
  input  logic [31:0]            p0_addr_i,
  input  logic [31:0]            p0_wdata_i,
  input  logic [3:0]             p0_be_i,
  output logic                   p0_ready_o,
  output logic [31:0]            p0_rdata_o,
  input  logic                   p1_req_i,
  input  logic                   p1_we_i,
  input  logic [31:0]            p1_addr_i,
  input  logic [31:0]            p1_wdata_i,
  input  logic [3:0]             p1_be_i,
  output logic                   p1_ready_o,
  output logic [31:0]            p1_rdata_o,
  output logic                   sram_ce_n_o,
  output logic                   sram_oe_n_o,
  output logic                   sram_we_n_o,
  output logic [SRAM_DW/8-1:0]   sram_be_n_o,
  output logic [SRAM_AW-1:0]     sram_addr_o,
  inout  wire  [SRAM_DW-1:0]     sram_dq_io
);

  localparam int WAW = SRAM_AW - 1;
  localparam int CW  = (ACC_CYC > 2) ? $clog2(ACC_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_CYC - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                gnt_q, gnt_d;
  logic                lastGrant_q, lastGrant_d;
  logic                we_q, we_d;
  logic [WAW-1:0]      wordAddr_q, wordAddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [15:0]         rdLo_q, rdLo_d;
  logic [31:0]         p0Rdata_q, p0Rdata_d;
  logic [31:0]         p1Rdata_q, p1Rdata_d;
  logic                p0Ready_q, p0Ready_d;
  logic                p1Ready_q, p1Ready_d;
  logic                ceN_q, ceN_d;
  logic                oeN_q, oeN_d;
  logic                weN_q, weN_d;
  logic [SRAM_DW/8-1:0] beN_q, beN_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic                dqOe_q, dqOe_d;
  logic [SRAM_DW-1:0]  dqOut_q, dqOut_d;

  logic phaseLast;
  logic inPhaseNext;
  logic hiNext;
  logic sampleDq;

  // Only the word-select bits of the byte address matter to the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{p0_addr_i[31:SRAM_AW+1], p0_addr_i[1:0],
                              p1_addr_i[31:SRAM_AW+1], p1_addr_i[1:0]};

  assign phaseLast = (cnt_q == LAST);

  // Sequencer and arbiter: picks a port in IDLE, latches its fields, then
  // walks through the LO/HI phases, skipping any write half with no enables.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    lastGrant_d = lastGrant_q;
    we_d        = we_q;
    wordAddr_d  = wordAddr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    case (state_q)
      IDLE: begin
        if (p0_req_i || p1_req_i) begin
          gnt_d      = (p0_req_i && p1_req_i) ? ~lastGrant_q : p1_req_i;
          we_d       = gnt_d ? p1_we_i : p0_we_i;
          wordAddr_d = gnt_d ? p1_addr_i[SRAM_AW:2] : p0_addr_i[SRAM_AW:2];
          wdata_d    = gnt_d ? p1_wdata_i : p0_wdata_i;
          be_d       = gnt_d ? p1_be_i : p0_be_i;
          cnt_d      = '0;
          if (!we_d || (be_d[1:0] != 2'b00)) begin
            state_d = LO;
          end else if (be_d[3:2] != 2'b00) begin
            state_d = HI;
          end else begin
            state_d = DONE;
          end
        end
      end
      LO: begin
        if (phaseLast) begin
          cnt_d   = '0;
          state_d = (we_q && (be_q[3:2] == 2'b00)) ? DONE : HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HI: begin
        if (phaseLast) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        lastGrant_d = gnt_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM pin and ready values for the coming cycle, decoded from the next
  // state so every pin leaves a flop and holds steady across a phase. The
  // write strobe releases one cycle early to give address/data hold time.
  // Read data is captured at the edge that closes each read phase.
  always_comb begin
    inPhaseNext = (state_d == LO) || (state_d == HI);
    hiNext      = (state_d == HI);
    sampleDq    = !we_q && phaseLast && ((state_q == LO) || (state_q == HI));
    ceN_d       = !inPhaseNext;
    oeN_d       = !(inPhaseNext && !we_d);
    weN_d       = !(inPhaseNext && we_d && (cnt_d != LAST));
    beN_d       = '1;
    if (inPhaseNext) begin
      beN_d = we_d ? ~(hiNext ? be_d[3:2] : be_d[1:0]) : '0;
    end
    addr_d    = inPhaseNext ? {wordAddr_d, hiNext} : '0;
    dqOe_d    = inPhaseNext && we_d;
    dqOut_d   = hiNext ? wdata_d[31:16] : wdata_d[15:0];
    p0Ready_d = (state_d == DONE) && !gnt_d;
    p1Ready_d = (state_d == DONE) && gnt_d;
    rdLo_d    = rdLo_q;
    p0Rdata_d = p0Rdata_q;
    p1Rdata_d = p1Rdata_q;
    if (sampleDq && (state_q == LO)) begin
      rdLo_d = sram_dq_io;
    end
    if (sampleDq && (state_q == HI)) begin
      if (gnt_q) begin
        p1Rdata_d = {sram_dq_io, rdLo_q};
      end else begin
        p0Rdata_d = {sram_dq_io, rdLo_q};
      end
    end
  end

  // All state and output registers; reset drops any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= 1'b0;
      lastGrant_q <= 1'b1;
      we_q        <= 1'b0;
      wordAddr_q  <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rdLo_q      <= '0;
      p0Rdata_q   <= '0;
      p1Rdata_q   <= '0;
      p0Ready_q   <= 1'b0;
      p1Ready_q   <= 1'b0;
      ceN_q       <= 1'b1;
      oeN_q       <= 1'b1;
      weN_q       <= 1'b1;
      beN_q       <= '1;
      addr_q      <= '0;
      dqOe_q      <= 1'b0;
      dqOut_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      lastGrant_q <= lastGrant_d;
      we_q        <= we_d;
      wordAddr_q  <= wordAddr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rdLo_q      <= rdLo_d;
      p0Rdata_q   <= p0Rdata_d;
      p1Rdata_q   <= p1Rdata_d;
      p0Ready_q   <= p0Ready_d;
      p1Ready_q   <= p1Ready_d;
      ceN_q       <= ceN_d;
      oeN_q       <= oeN_d;
      weN_q       <= weN_d;
      beN_q       <= beN_d;
      addr_q      <= addr_d;
      dqOe_q      <= dqOe_d;
      dqOut_q     <= dqOut_d;
    end
  end

  assign p0_ready_o  = p0Ready_q;
  assign p1_ready_o  = p1Ready_q;
  assign p0_rdata_o  = p0Rdata_q;
  assign p1_rdata_o  = p1Rdata_q;
  assign sram_ce_n_o = ceN_q;
  assign sram_oe_n_o = oeN_q;
  assign sram_we_n_o = weN_q;
  assign sram_be_n_o = beN_q;
  assign sram_addr_o = addr_q;
  assign sram_dq_io  = dqOe_q ? dqOut_q : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Drives both request ports of sram_arbiter against a behavioural SRAM and a
// word-level reference memory. Each issued request pushes its expected result
// onto a per-port queue; a separate monitor pops and compares on every ready
// pulse, including the SRAM pin activity seen while the access ran.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int ACC_CYC = 2;

  typedef struct {
    logic        we;
    logic [6:0]  word;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] expData;
    int          issue;
    int          lat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p0_be, p1_be;
  logic        p0_ready, p1_ready;
  logic [31:0] p0_rdata, p1_rdata;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0]  sram_be_n;
  logic [18:0] sram_addr;
  wire  [15:0] sram_dq;

  logic [31:0] refMem [128];
  logic [15:0] mem [256];
  logic        memLoad;
  logic [31:0] lastRead [2];
  txn_t        sb0[$];
  txn_t        sb1[$];
  logic [38:0] traceQ[$];
  int          donePort[$];
  int          doneCycle[$];
  int          cycleCnt = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          stall = 0;

  sram_arbiter #(.SRAM_AW(19), .SRAM_DW(16), .ACC_CYC(ACC_CYC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr),
    .p0_wdata_i(p0_wdata), .p0_be_i(p0_be),
    .p0_ready_o(p0_ready), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr),
    .p1_wdata_i(p1_wdata), .p1_be_i(p1_be),
    .p1_ready_o(p1_ready), .p1_rdata_o(p1_rdata),
    .sram_ce_n_o(sram_ce_n), .sram_oe_n_o(sram_oe_n), .sram_we_n_o(sram_we_n),
    .sram_be_n_o(sram_be_n), .sram_addr_o(sram_addr), .sram_dq_io(sram_dq)
  );

  // Free-running clock and a cycle counter used for latency measurements.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Asynchronous SRAM model: drives the bus when output-enabled and not
  // writing; stores the enabled byte lanes while the write strobe is low.
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] : 16'bz;

  always @(posedge clk) begin
    if (memLoad) begin
      for (int i = 0; i < 128; i++) begin
        mem[2*i]   <= refMem[i][15:0];
        mem[2*i+1] <= refMem[i][31:16];
      end
    end else if (rst_n && !sram_ce_n && !sram_we_n) begin
      if (!sram_be_n[0]) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!sram_be_n[1]) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  function automatic logic [38:0] packEntry(input logic [18:0] a, input logic oe,
                                            input logic we, input logic [1:0] ben,
                                            input logic [15:0] dq);
    return {a, oe, we, ben, dq};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cycleCnt);
    end
  endtask

  // Rebuilds the pin activity an access must produce from its fields and
  // compares it, the returned data and (when known) the latency.
  task automatic checkTxn(input int port);
    txn_t        t;
    logic [38:0] expT[$];
    logic [1:0]  bh;
    logic [15:0] dqExp;
    int          n;
    checkOutput(port == 0 ? "p0 readyWithPending" : "p1 readyWithPending",
                (port == 0 ? sb0.size() : sb1.size()) > 0, 1);
    if ((port == 0 ? sb0.size() : sb1.size()) == 0) return;
    t = (port == 0) ? sb0.pop_front() : sb1.pop_front();
    for (int h = 0; h < 2; h++) begin
      bh = (h == 1) ? t.be[3:2] : t.be[1:0];
      if (!t.we || bh != 2'b00) begin
        for (int c = 0; c < ACC_CYC; c++) begin
          if (t.we) dqExp = (h == 1) ? t.wdata[31:16] : t.wdata[15:0];
          else      dqExp = (h == 1) ? t.expData[31:16] : t.expData[15:0];
          expT.push_back(packEntry({11'b0, t.word, 1'(h)}, t.we,
                                   !(t.we && c < ACC_CYC - 1),
                                   t.we ? ~bh : 2'b00, dqExp));
        end
      end
    end
    checkOutput("traceLength", traceQ.size(), expT.size());
    n = (traceQ.size() < expT.size()) ? traceQ.size() : expT.size();
    for (int i = 0; i < n; i++) checkOutput("traceEntry", traceQ[i], expT[i]);
    checkOutput(port == 0 ? "p0 rdata" : "p1 rdata",
                port == 0 ? p0_rdata : p1_rdata,
                t.we ? lastRead[port] : t.expData);
    if (!t.we) lastRead[port] = t.expData;
    if (t.lat >= 0) checkOutput("latency", cycleCnt + 1 - t.issue, t.lat);
    donePort.push_back(port);
    doneCycle.push_back(cycleCnt);
  endtask

  // Monitor: records SRAM activity each cycle and checks every ready pulse
  // against the scoreboard; a stall with pending work counts as a failure.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !sram_ce_n)
        traceQ.push_back(packEntry(sram_addr, sram_oe_n, sram_we_n, sram_be_n, sram_dq));
      if (p0_ready && p1_ready) checkOutput("singleReady", {p0_ready, p1_ready}, 2'b10);
      if (p0_ready) checkTxn(0);
      if (p1_ready) checkTxn(1);
      if (p0_ready || p1_ready) begin
        traceQ.delete();
        stall = 0;
      end else if (sb0.size() + sb1.size() > 0) begin
        stall++;
        if (stall > 100) begin
          checkOutput("watchdogPending", sb0.size() + sb1.size(), 0);
          sb0.delete();
          sb1.delete();
          stall = 0;
        end
      end
    end
  end

  // Presents one request, records its expected result and waits for ready.
  task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input int lat);
    txn_t t;
    int   w;
    w        = int'(addr[8:2]);
    t.we     = we;
    t.word   = addr[8:2];
    t.wdata  = wdata;
    t.be     = be;
    t.issue  = cycleCnt + 1;
    t.lat    = lat;
    t.expData = 32'h0;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) refMem[w][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      t.expData = refMem[w];
    end
    if (port == 0) begin
      p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_be = be; p0_req = 1'b1;
      sb0.push_back(t);
    end else begin
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_be = be; p1_req = 1'b1;
      sb1.push_back(t);
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (port == 0 ? p0_ready : p1_ready) break;
    end
  endtask

  task automatic releaseReq(input int port);
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
  endtask

  // Random traffic for one port in its own address region so that per-port
  // ordering alone determines every expected read value.
  task automatic runRandom(input int port, input int count);
    logic [31:0] r;
    logic [6:0]  word;
    int          gap;
    for (int i = 0; i < count; i++) begin
      r    = $urandom();
      word = 7'(port * 64 + int'($urandom_range(0, 63)));
      applyStimulus(port, 1'($urandom_range(0, 1)), {r[31:20], 11'b0, word, r[1:0]},
                    $urandom(), 4'($urandom_range(0, 15)), -1);
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        releaseReq(port);
        repeat (gap) @(negedge clk);
      end
    end
    releaseReq(port);
  endtask

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout: got cycle %0d, expected completion", cycleCnt);
    $fatal(1, "[TB] run did not complete");
  end

  // Directed scenarios followed by randomized two-port traffic.
  initial begin
    logic found;
    rst_n = 1'b0; memLoad = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_be = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_be = 0;
    for (int w = 0; w < 128; w++) refMem[w] = $urandom();
    refMem[4] = 32'hDEAD_BEEF;
    refMem[8] = 32'h5566_7788;
    lastRead[0] = 32'h0;
    lastRead[1] = 32'h0;
    repeat (3) @(posedge clk);
    memLoad = 1'b0;
    @(negedge clk);
    checkOutput("resetCeN", sram_ce_n, 1'b1);
    checkOutput("resetOeN", sram_oe_n, 1'b1);
    checkOutput("resetWeN", sram_we_n, 1'b1);
    checkOutput("resetBeN", sram_be_n, 2'b11);
    checkOutput("resetAddr", sram_addr, 19'h0);
    checkOutput("resetReady", {p0_ready, p1_ready}, 2'b00);
    checkOutput("resetRdata0", p0_rdata, 32'h0);
    checkOutput("resetRdata1", p1_rdata, 32'h0);
    rst_n = 1'b1;

    fork
      begin
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, 5);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, -1);
        releaseReq(0);
      end
      begin
        applyStimulus(1, 1'b0, 32'h14, 32'h0, 4'hF, -1);
        applyStimulus(1, 1'b0, 32'h14, 32'h0, 4'hF, -1);
        releaseReq(1);
      end
    join
    checkOutput("contentionCount", donePort.size(), 4);
    for (int i = 0; i < donePort.size() && i < 4; i++) begin
      checkOutput("grantOrder", donePort[i], i % 2);
      if (i > 0) checkOutput("readySpacing", doneCycle[i] - doneCycle[i-1], 2 + 2 * ACC_CYC);
    end
    @(negedge clk);

    applyStimulus(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1 + 2 * ACC_CYC);
    releaseReq(0); @(negedge clk);
    applyStimulus(1, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1100, 1 + ACC_CYC);
    releaseReq(1); @(negedge clk);
    applyStimulus(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1 + 2 * ACC_CYC);
    releaseReq(0); @(negedge clk);
    applyStimulus(0, 1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'b0000, 1);
    releaseReq(0); @(negedge clk);
    applyStimulus(1, 1'b0, 32'h0000_0030, 32'h0, 4'hF, 1 + 2 * ACC_CYC);
    releaseReq(1); @(negedge clk);
    applyStimulus(1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 1 + 2 * ACC_CYC);
    releaseReq(1); @(negedge clk);
    applyStimulus(0, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 1 + 2 * ACC_CYC);
    releaseReq(0); @(negedge clk);

    p0_we = 1'b0; p0_addr = 32'h10; p0_be = 4'hF; p0_req = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!sram_ce_n && sram_addr[0]) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reachedHiPhase", found, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("abortCeN", sram_ce_n, 1'b1);
    checkOutput("abortOeN", sram_oe_n, 1'b1);
    p0_req = 1'b0;
    traceQ.delete();
    lastRead[0] = 32'h0;
    lastRead[1] = 32'h0;
    @(negedge clk);
    checkOutput("abortRdata", p0_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1 + 2 * ACC_CYC);
    releaseReq(0); @(negedge clk);

    fork
      runRandom(0, 15);
      runRandom(1, 15);
    join
    repeat (5) @(negedge clk);
    checkOutput("drainPending", sb0.size() + sb1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
